// File: rtl/hs32_wb_pkg.sv
// Shared types and helpers for the Wishbone init sequencer.
// Defines the FSM states, the bus widths and the table entry lookup.
package hs32_wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STROBE = 3'd1,
        ST_GAP    = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAIL   = 3'd4
    } wb_seq_state_e;

    localparam int ENTRY_W   = 64;
    localparam int ADR_W     = 32;
    localparam int DAT_W     = 32;
    localparam int MAX_TRANS = 255;
    localparam int TBL_W     = MAX_TRANS * ENTRY_W;

    // Entry 0 sits in the most-significant 64 bits of the table.
    function automatic logic [ENTRY_W-1:0] entry_at(input logic [TBL_W-1:0] tbl,
                                                    input int num_trans,
                                                    input int idx);
        return tbl[(num_trans - 1 - idx) * ENTRY_W +: ENTRY_W];
    endfunction

endpackage

// File: rtl/wb_init_seq_if.sv
// Single-word Wishbone write bus between the init sequencer and the slave.
interface wb_init_seq_if;
    logic                           cyc;
    logic                           stb;
    logic                           we;
    logic [3:0]                     sel;
    logic [hs32_wb_pkg::ADR_W-1:0]  adr;
    logic [hs32_wb_pkg::DAT_W-1:0]  dat;
    logic                           ack;
    logic                           err;

    modport master (output cyc, stb, we, sel, adr, dat, input ack, err);
    modport slave  (input cyc, stb, we, sel, adr, dat, output ack, err);
endinterface

// File: rtl/wb_ack_timeout.sv
// Ack-wait counter: clears to zero, counts while enabled and flags when
// it has reached TIMEOUT; it saturates there until cleared.
module wb_ack_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             expired_s;

    // Compare the running count against the limit.
    always_comb begin
        expired_s = (cnt_q == CNT_W'(TIMEOUT));
    end

    // Count register with clear priority over enable.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_s) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign expired_o = expired_s;
endmodule

// File: rtl/wb_init_seq.sv
// Wishbone master that replays a fixed table of single-word writes after
// reset or on request and reports done / error / failing entry index.
module wb_init_seq
    import hs32_wb_pkg::*;
#(
    parameter int                           NUM_TRANS  = 4,
    parameter logic [NUM_TRANS*ENTRY_W-1:0] ENTRIES    = '0,
    parameter int                           TIMEOUT    = 255,
    parameter bit                           AUTO_START = 1'b1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 start_i,
    wb_init_seq_if.master        wbm,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [7:0]           err_idx_o
);
    localparam logic [TBL_W-1:0]   TBL    = TBL_W'(ENTRIES);
    localparam logic [ENTRY_W-1:0] ENTRY0 = entry_at(TBL, NUM_TRANS, 0);
    localparam logic [7:0]         LAST   = 8'(NUM_TRANS - 1);

    wb_seq_state_e      state_q;
    logic [7:0]         ip_q;
    logic               first_q;
    logic               cyc_q, stb_q, we_q;
    logic [3:0]         sel_q;
    logic [ADR_W-1:0]   adr_q;
    logic [DAT_W-1:0]   dat_q;
    logic               busy_q, done_q, error_q;
    logic [7:0]         err_idx_q;

    logic [ENTRY_W-1:0] entry_s;
    logic               run_req_s;
    logic               tmo_clr_s, tmo_en_s, tmo_expired_s;

    // Current entry lookup, run request and timeout control.
    always_comb begin
        entry_s   = entry_at(TBL, NUM_TRANS, int'(ip_q));
        run_req_s = start_i || (AUTO_START && first_q);
        tmo_clr_s = (state_q != ST_STROBE);
        tmo_en_s  = (state_q == ST_STROBE) && !wbm.ack && !wbm.err;
    end

    wb_ack_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (wb_clk_i),
        .rst_ni    (wb_rst_ni),
        .clr_i     (tmo_clr_s),
        .en_i      (tmo_en_s),
        .expired_o (tmo_expired_s)
    );

    // Sequencer FSM with all bus and status outputs registered.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            ip_q      <= 8'd0;
            first_q   <= 1'b1;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 4'h0;
            adr_q     <= '0;
            dat_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= 8'd0;
        end else begin
            first_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (run_req_s) begin
                        state_q   <= ST_STROBE;
                        ip_q      <= 8'd0;
                        cyc_q     <= 1'b1;
                        stb_q     <= 1'b1;
                        we_q      <= 1'b1;
                        sel_q     <= 4'hF;
                        adr_q     <= ENTRY0[ENTRY_W-1 -: ADR_W];
                        dat_q     <= ENTRY0[DAT_W-1:0];
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        error_q   <= 1'b0;
                        err_idx_q <= 8'd0;
                    end
                end
                ST_STROBE: begin
                    // err beats ack; an ack on the expiry cycle still completes.
                    if (wbm.err || (!wbm.ack && tmo_expired_s)) begin
                        state_q   <= ST_FAIL;
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        we_q      <= 1'b0;
                        sel_q     <= 4'h0;
                        busy_q    <= 1'b0;
                        error_q   <= 1'b1;
                        err_idx_q <= ip_q;
                    end else if (wbm.ack) begin
                        stb_q <= 1'b0;
                        we_q  <= 1'b0;
                        sel_q <= 4'h0;
                        if (ip_q == LAST) begin
                            state_q <= ST_DONE;
                            cyc_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_GAP;
                            ip_q    <= ip_q + 8'd1;
                        end
                    end
                end
                ST_GAP: begin
                    state_q <= ST_STROBE;
                    stb_q   <= 1'b1;
                    we_q    <= 1'b1;
                    sel_q   <= 4'hF;
                    adr_q   <= entry_s[ENTRY_W-1 -: ADR_W];
                    dat_q   <= entry_s[DAT_W-1:0];
                end
                default: begin
                    state_q <= ST_IDLE;
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    we_q    <= 1'b0;
                    sel_q   <= 4'h0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wbm.cyc   = cyc_q;
    assign wbm.stb   = stb_q;
    assign wbm.we    = we_q;
    assign wbm.sel   = sel_q;
    assign wbm.adr   = adr_q;
    assign wbm.dat   = dat_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign error_o   = error_q;
    assign err_idx_o = err_idx_q;
endmodule

// File: tb/tb_wb_init_seq.sv
// Bench for wb_init_seq: a per-cycle timeline model derived from the slave
// response plan, plus a second instance exercising manual start only.
module tb_wb_init_seq;
    localparam int N   = 4;
    localparam int TMO = 15;
    localparam logic [N*64-1:0] TBL = {64'h0000FF00_0000CA00, 64'h0000CA84_FFFFFFFF,
                                       64'h0000CAA4_00000010, 64'h0000CAA0_00000029};

    logic [31:0] ref_adr [N] = '{32'h0000FF00, 32'h0000CA84, 32'h0000CAA4, 32'h0000CAA0};
    logic [31:0] ref_dat [N] = '{32'h0000CA00, 32'hFFFFFFFF, 32'h00000010, 32'h00000029};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rst2_n, start1, start2;
    logic       busy1, done1, error1, busy2, done2, error2;
    logic [7:0] idx1, idx2;

    wb_init_seq_if bus1 ();
    wb_init_seq_if bus2 ();

    assign bus2.ack = bus2.stb;
    assign bus2.err = 1'b0;

    wb_init_seq #(.NUM_TRANS(N), .ENTRIES(TBL), .TIMEOUT(TMO), .AUTO_START(1'b1)) dut1 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start1), .wbm(bus1),
        .busy_o(busy1), .done_o(done1), .error_o(error1), .err_idx_o(idx1));

    wb_init_seq #(.NUM_TRANS(N), .ENTRIES(TBL), .TIMEOUT(255), .AUTO_START(1'b0)) dut2 (
        .wb_clk_i(clk), .wb_rst_ni(rst2_n), .start_i(start2), .wbm(bus2),
        .busy_o(busy2), .done_o(done2), .error_o(error2), .err_idx_o(idx2));

    int n_cmp = 0;
    int n_err = 0;

    // Slave response plan per entry: kind 0 = ack, 1 = err, 2 = never respond.
    int p_kind [N];
    int p_wait [N];
    bit p_both [N];
    logic [31:0] mem [logic [31:0]];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic plan_zero();
        for (int i = 0; i < N; i++) begin
            p_kind[i] = 0;
            p_wait[i] = 0;
            p_both[i] = 1'b0;
        end
    endtask

    // Runs one sequence from edge 0; abort_c > 0 pulses reset in that cycle.
    task automatic run_seq(input bit use_start, input int abort_c);
        int tl [0:127];
        int t, t_end, status, fidx, run_len, ent, dur;
        logic [17:0] exp_p, obs_p;
        bit s;
        for (int k = 0; k < 128; k++) tl[k] = -1;
        t = 1; status = 0; fidx = 0;
        for (int i = 0; i < N; i++) begin
            dur = (p_kind[i] == 2) ? TMO + 1 : p_wait[i] + 1;
            for (int d = 0; d < dur; d++) begin
                tl[t] = i;
                t++;
            end
            if (p_kind[i] != 0) begin status = 2; fidx = i; break; end
            if (i == N - 1) begin status = 1; break; end
            t++;
        end
        t_end = t;

        mem.delete();
        start1 = use_start; bus1.ack = 1'b0; bus1.err = 1'b0;
        @(posedge clk);
        #1 start1 = 1'b0;
        run_len = 0; ent = -1;
        for (int c = 1; c <= t_end + 2; c++) begin
            @(negedge clk);
            if (c < t_end) begin
                s = (tl[c] >= 0);
                exp_p = {1'b1, s, s, s ? 4'hF : 4'h0, 1'b1, 1'b0, 1'b0, 8'h00};
            end else begin
                exp_p = {1'b0, 1'b0, 1'b0, 4'h0, 1'b0, status == 1, status == 2,
                         (status == 2) ? 8'(fidx) : 8'h00};
            end
            obs_p = {bus1.cyc, bus1.stb, bus1.stb & bus1.we, bus1.sel, busy1, done1, error1, idx1};
            check_val($sformatf("ctl c%0d", c), 64'(obs_p), 64'(exp_p));
            if (c < t_end && tl[c] >= 0) begin
                check_val($sformatf("adr c%0d", c), 64'(bus1.adr), 64'(ref_adr[tl[c]]));
                check_val($sformatf("dat c%0d", c), 64'(bus1.dat), 64'(ref_dat[tl[c]]));
            end
            if (c == abort_c) begin
                rst_n = 1'b0; bus1.ack = 1'b0; bus1.err = 1'b0; start1 = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_val("rst ctl", 64'({bus1.cyc, bus1.stb, bus1.we, bus1.sel, busy1, done1, error1, idx1}), 64'h0);
                check_val("rst adr", 64'(bus1.adr), 64'h0);
                check_val("rst dat", 64'(bus1.dat), 64'h0);
                rst_n = 1'b1;
                return;
            end
            bus1.ack = 1'b0; bus1.err = 1'b0;
            if (bus1.stb) begin
                if (run_len == 0) ent++;
                run_len++;
                if (ent >= 0 && ent < N && p_kind[ent] != 2 && run_len == p_wait[ent] + 1) begin
                    if (p_kind[ent] == 0) begin
                        bus1.ack = 1'b1;
                        mem[bus1.adr] = bus1.dat;
                    end else begin
                        bus1.err = 1'b1;
                        bus1.ack = p_both[ent];
                    end
                end
            end else begin
                run_len = 0;
                bus1.ack = ($urandom_range(0, 3) == 0);
                bus1.err = ($urandom_range(0, 3) == 0);
            end
            start1 = (c < t_end) ? ($urandom_range(0, 4) == 0) : 1'b0;
        end
        bus1.ack = 1'b0; bus1.err = 1'b0; start1 = 1'b0;
        if (status == 1) begin
            for (int i = 0; i < N; i++)
                check_val($sformatf("mem%0d", i),
                          64'(mem.exists(ref_adr[i]) ? mem[ref_adr[i]] : 32'hDEADBEEF),
                          64'(ref_dat[i]));
        end
    endtask

    initial begin
        int bad, stb_cnt, done_at, r;
        rst_n = 1'b0; rst2_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
        bus1.ack = 1'b0; bus1.err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset ctl", 64'({bus1.cyc, bus1.stb, bus1.we, bus1.sel, busy1, done1, error1, idx1}), 64'h0);
        check_val("reset adr", 64'(bus1.adr), 64'h0);

        // Auto-start with a zero-wait slave.
        rst_n = 1'b1;
        plan_zero();
        run_seq(1'b0, -1);

        // Three wait states on entry 1.
        plan_zero(); p_wait[1] = 3;
        run_seq(1'b1, -1);

        // Entry 2 never acked: timeout.
        plan_zero(); p_kind[2] = 2;
        run_seq(1'b1, -1);

        // err and ack together on entry 0, then a clean replay.
        plan_zero(); p_kind[0] = 1; p_both[0] = 1'b1;
        run_seq(1'b1, -1);
        plan_zero();
        run_seq(1'b1, -1);

        // Randomized slave behaviour.
        repeat (10) begin
            for (int i = 0; i < N; i++) begin
                r = int'($urandom_range(0, 9));
                p_kind[i] = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
                p_wait[i] = int'($urandom_range(0, 3));
                p_both[i] = 1'($urandom_range(0, 1));
            end
            run_seq(1'b1, -1);
        end

        // Reset in the gap after entry 1, then auto-start from entry 0.
        plan_zero();
        run_seq(1'b1, 4);
        run_seq(1'b0, -1);

        // Manual-start instance: idle, then start, ignoring starts while busy.
        @(negedge clk);
        rst2_n = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus2.cyc || bus2.stb || busy2) bad++;
        end
        check_val("no auto activity", 64'(bad), 64'h0);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        @(negedge clk);
        check_val("start stb", 64'(bus2.stb), 64'h1);
        check_val("start adr", 64'(bus2.adr), 64'h0000FF00);
        stb_cnt = 0; done_at = 0;
        for (int c = 1; c <= 40; c++) begin
            if (bus2.stb) stb_cnt++;
            if (done2 && done_at == 0) done_at = c;
            if (done_at != 0) begin
                start2 = 1'b0;
                break;
            end
            start2 = (c == 2 || c == 3) ? 1'b1 : (busy2 ? 1'($urandom_range(0, 1)) : 1'b0);
            @(negedge clk);
        end
        start2 = 1'b0;
        check_val("manual done cycle", 64'(done_at), 64'd8);
        check_val("manual stb cycles", 64'(stb_cnt), 64'd4);
        check_val("manual error", 64'({error2, idx2}), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
